// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control path: opcodes, sequencer
// states and the mux/ALU select encodings used by the datapath.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] ALU_B_REG    = 2'b00;
    localparam logic [1:0] ALU_B_FOUR   = 2'b01;
    localparam logic [1:0] ALU_B_IMM    = 2'b10;
    localparam logic [1:0] ALU_B_IMM_SH = 2'b11;

    // States that hold a memory request open and are watched by the timer.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of an outstanding memory request and
// flags the cycle in which the wait budget runs out.
module mem_wait_timer #(
    parameter int WAIT_TIMEOUT = 16,
    parameter int CNT_W        = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic ready,
    output logic timeout
);

    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(WAIT_TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt_reg;

    // Ready in the final wait cycle takes priority over the timeout.
    assign timeout = start && !ready && (wait_cnt_reg == LAST_WAIT);

    // Any cycle that is not a continued wait clears the count, so every entry
    // into a wait state (including a retry after timeout) starts from zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_reg <= '0;
        end else if (start && !ready && !timeout) begin
            wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
        end else begin
            wait_cnt_reg <= '0;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: steps through fetch, decode, execute and
// writeback, driving datapath selects and the memory request handshake.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 16,
    parameter int CNT_W        = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_dst,
    output logic       mem2reg,
    output logic       we3,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       bus_err,
    output logic [3:0] state_o
);

    state_t state_reg;
    logic   in_wait;
    logic   timeout;

    assign in_wait = rst_n && is_wait_state(state_reg);

    mem_wait_timer #(
        .WAIT_TIMEOUT(WAIT_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (in_wait),
        .ready  (mem_ready),
        .timeout(timeout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    if (mem_ready) state_reg <= S_DECODE;
                end
                S_DECODE: begin
                    case (opcode)
                        OP_RTYPE:     state_reg <= S_EXEC;
                        OP_LW, OP_SW: state_reg <= S_MEMADR;
                        OP_BEQ:       state_reg <= S_BRANCH;
                        OP_ADDI:      state_reg <= S_ADDIEX;
                        OP_J:         state_reg <= S_JUMP;
                        default:      state_reg <= S_FETCH;
                    endcase
                end
                S_MEMADR: state_reg <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD: begin
                    if (mem_ready)    state_reg <= S_MEMWB;
                    else if (timeout) state_reg <= S_FETCH;
                end
                S_MEMWR: begin
                    if (mem_ready || timeout) state_reg <= S_FETCH;
                end
                S_EXEC:   state_reg <= S_ALUWB;
                S_ADDIEX: state_reg <= S_ADDIWB;
                // Writeback/branch/jump states and any stray encoding return to fetch.
                default:  state_reg <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_en      = 1'b0;
        pc_src     = PC_SRC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = ALU_B_REG;
        alu_op     = ALU_OP_ADD;
        reg_dst    = 1'b0;
        mem2reg    = 1'b0;
        we3        = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        bus_err    = 1'b0;
        state_o    = 4'd0;
        if (rst_n) begin
            state_o = state_reg;
            bus_err = timeout;
            case (state_reg)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = ALU_B_FOUR;
                    ir_we     = mem_ready;
                    pc_en     = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = ALU_B_IMM_SH;
                    case (opcode)
                        OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
                        default: illegal_op = 1'b1;
                    endcase
                end
                S_MEMADR, S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ALU_B_IMM;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWB: begin
                    mem2reg    = 1'b1;
                    we3        = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    mem_req    = 1'b1;
                    mem_we     = 1'b1;
                    iord       = 1'b1;
                    instr_done = mem_ready;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_OP_FUNCT;
                end
                S_ALUWB: begin
                    reg_dst    = 1'b1;
                    we3        = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_op     = ALU_OP_SUB;
                    pc_src     = PC_SRC_ALUOUT;
                    pc_en      = zero;
                    instr_done = 1'b1;
                end
                S_ADDIWB: begin
                    we3        = 1'b1;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    pc_src     = PC_SRC_JUMP;
                    pc_en      = 1'b1;
                    instr_done = 1'b1;
                end
                default: state_o = state_reg;
            endcase
        end
    end

endmodule
